lbp_hist: RTL and testbench

- Downstream consumer of the LBP engine's result stream (lbp_addr / lbp_valid / lbp_data / finish).
- Builds a 256-bin histogram of LBP codes for interior pixels of a 128x128 image.
- After finish, streams the histogram out over a valid/ready handshake, one bin per transfer, bins 0..255.
- Sits between the LBP engine and the feature/host interface.

---
 rtl/lbp_hist_if.sv | 29 ++
 rtl/lbp_hist.sv | 97 +++++++++
 tb/tb_lbp_hist.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_hist_if.sv
// Bundle of the LBP result stream and the histogram drain handshake.
// The block itself uses the slave view; the producer/consumer side uses the master view.
interface lbp_hist_if #(
  parameter int IMG_W = 128,
  parameter int CNT_W = 14
) ();
  localparam int ADDR_W = 2 * $clog2(IMG_W);

  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_valid;
  logic [7:0]        lbp_data;
  logic              finish;
  logic              hist_valid;
  logic              hist_ready;
  logic [7:0]        hist_bin;
  logic [CNT_W-1:0]  hist_count;
  logic              hist_done;
  logic              border_err;

  modport master (
    output lbp_addr, lbp_valid, lbp_data, finish, hist_ready,
    input  hist_valid, hist_bin, hist_count, hist_done, border_err
  );

  modport slave (
    input  lbp_addr, lbp_valid, lbp_data, finish, hist_ready,
    output hist_valid, hist_bin, hist_count, hist_done, border_err
  );
endinterface

// File: rtl/lbp_hist.sv
// 256-bin histogram of LBP codes for interior pixels, drained one bin per
// valid/ready transfer once the engine signals finish.
module lbp_hist #(
  parameter int IMG_W = 128,
  parameter int CNT_W = 14
) (
  input  logic       clk,
  input  logic       reset,
  lbp_hist_if.slave  bus
);
  localparam int LOG    = $clog2(IMG_W);
  localparam int ADDR_W = 2 * LOG;

  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_bin [256];
  logic [7:0]        r_ptr;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last_vld;
  logic              r_border_err;

  logic [LOG-1:0]    w_row;
  logic [LOG-1:0]    w_col;
  logic              w_accept;
  logic              w_border;
  logic              w_count;
  logic              w_xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_row    = bus.lbp_addr[ADDR_W-1:LOG];
  assign w_col    = bus.lbp_addr[LOG-1:0];
  assign w_border = (w_row == '0) || (&w_row) || (w_col == '0) || (&w_col);
  // A held result repeats its address; only an address change is a new sample.
  assign w_accept = (r_state == ACC) && bus.lbp_valid &&
                    (!r_last_vld || (bus.lbp_addr != r_last_addr));
  assign w_count  = w_accept && !w_border;
  assign w_xfer   = (r_state == DRAIN) && bus.hist_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ACC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (bus.finish) w_state_nxt = DRAIN;
      DRAIN:   if (w_xfer && (r_ptr == 8'hFF)) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = ACC;
    endcase
  end

  always_comb begin
    bus.hist_valid = 1'b0;
    bus.hist_done  = 1'b0;
    bus.hist_bin   = r_ptr;
    bus.hist_count = '0;
    bus.border_err = r_border_err;
    if (r_state == DRAIN) begin
      bus.hist_valid = 1'b1;
      bus.hist_count = r_bin[r_ptr];
    end
    if (r_state == DONE) bus.hist_done = 1'b1;
  end

  // Single-cycle read-modify-write: a sample accepted on the finish edge
  // lands in its bin on the same edge that enters DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) r_bin[i] <= '0;
    end else if (w_count) begin
      r_bin[bus.lbp_data] <= sat_inc(r_bin[bus.lbp_data]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_addr  <= '0;
      r_last_vld   <= 1'b0;
      r_border_err <= 1'b0;
      r_ptr        <= '0;
    end else begin
      if (w_accept) begin
        r_last_addr <= bus.lbp_addr;
        r_last_vld  <= 1'b1;
        if (w_border) r_border_err <= 1'b1;
      end
      if (w_xfer) r_ptr <= r_ptr + 8'd1;
    end
  end
endmodule

// File: tb/tb_lbp_hist.sv
// Randomised bench for lbp_hist: a behavioural histogram model predicts every
// drained bin, with literal expectations for the directed scenarios.
module tb_lbp_hist;
  localparam int IMG_W = 128;
  localparam int CNT_W = 14;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lbp_hist_if #(.IMG_W(IMG_W), .CNT_W(CNT_W)) bus ();

  lbp_hist #(.IMG_W(IMG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model: phase 0 = collecting, 1 = streaming bins, 2 = finished
  int m_bin [256];
  int m_phase;
  int m_ptr;
  bit m_seen;
  int m_last;
  bit m_berr;

  int got [256];
  int hs_cnt;
  bit prev_stall;
  logic [7:0]       prev_bin;
  logic [CNT_W-1:0] prev_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_bin[i]) m_bin[i] = 0;
      m_phase = 0; m_ptr = 0; m_seen = 0; m_last = 0; m_berr = 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.lbp_valid && (!m_seen || int'(bus.lbp_addr) != m_last)) begin
            int r, c;
            m_seen = 1;
            m_last = int'(bus.lbp_addr);
            r = m_last / IMG_W;
            c = m_last % IMG_W;
            if (r == 0 || r == IMG_W-1 || c == 0 || c == IMG_W-1) m_berr = 1;
            else if (m_bin[bus.lbp_data] < MAXC) m_bin[bus.lbp_data]++;
          end
          if (bus.finish) m_phase = 1;
        end
        1: if (bus.hist_ready) begin
          if (m_ptr == 255) m_phase = 2;
          m_ptr++;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_cnt = 0;
      prev_stall = 0;
    end else begin
      chk("hist_valid", 32'(bus.hist_valid), 32'(m_phase == 1));
      chk("hist_done", 32'(bus.hist_done), 32'(m_phase == 2));
      chk("border_err", 32'(bus.border_err), 32'(m_berr));
      if (bus.hist_valid) begin
        chk("hist_bin", 32'(bus.hist_bin), 32'(m_ptr));
        chk("hist_count", 32'(bus.hist_count), 32'(m_bin[m_ptr & 255]));
      end
      if (prev_stall && bus.hist_valid) begin
        chk("stall_bin", 32'(bus.hist_bin), 32'(prev_bin));
        chk("stall_count", 32'(bus.hist_count), 32'(prev_cnt));
      end
      if (bus.hist_valid && bus.hist_ready) begin
        chk("order", 32'(bus.hist_bin), 32'(hs_cnt % 256));
        got[bus.hist_bin] = int'(bus.hist_count);
        hs_cnt++;
      end
      prev_stall = bus.hist_valid && !bus.hist_ready;
      prev_bin   = bus.hist_bin;
      prev_cnt   = bus.hist_count;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = '0;
    bus.lbp_data   = '0;
    bus.finish     = 1'b0;
    bus.hist_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    foreach (got[i]) got[i] = -1;
    step();
  endtask

  task automatic put(input int a, input int d);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'(a);
    bus.lbp_data  = 8'(d);
  endtask

  // mode 0: always ready; 1: 1,0,0 repeating; 2: random
  task automatic drain(input int mode);
    int k = 0;
    while (!bus.hist_done && k < 3000) begin
      case (mode)
        0: bus.hist_ready = 1'b1;
        1: bus.hist_ready = (k % 3 == 0);
        default: bus.hist_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      k++;
    end
    chk("done_reached", 32'(bus.hist_done), 32'd1);
  endtask

  function automatic int rand_addr();
    int r, c;
    if ($urandom_range(0, 9) == 0) begin
      r = $urandom_range(0, 1) ? 0 : IMG_W-1;
      c = $urandom_range(0, IMG_W-1);
      return $urandom_range(0, 1) ? (r * IMG_W + c) : (c * IMG_W + r);
    end
    r = $urandom_range(1, IMG_W-2);
    c = $urandom_range(1, IMG_W-2);
    return r * IMG_W + c;
  endfunction

  task automatic random_image(input int n);
    for (int s = 0; s < n; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.lbp_valid = 1'b0;
        step();
      end else begin
        int a = rand_addr();
        int d = $urandom_range(0, 4) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 15);
        put(a, d);
        repeat ($urandom_range(1, 3)) step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(bus.hist_valid), 32'd0);
    chk("rst_bin", 32'(bus.hist_bin), 32'd0);
    chk("rst_count", 32'(bus.hist_count), 32'd0);
    chk("rst_done", 32'(bus.hist_done), 32'd0);
    chk("rst_berr", 32'(bus.border_err), 32'd0);
    do_reset();

    // 16 interior samples, each held for 3 cycles
    for (int i = 0; i < 16; i++) begin
      put(129 + i, 8'h05);
      repeat (3) step();
    end
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b1;
    drain(0);
    chk("t1_bin5", 32'(got[5]), 32'd16);
    chk("t1_bin0", 32'(got[0]), 32'd0);
    chk("t1_bin6", 32'(got[6]), 32'd0);
    chk("t1_bin255", 32'(got[255]), 32'd0);
    chk("t1_handshakes", 32'(hs_cnt), 32'd256);
    repeat (3) step();
    chk("t1_done_held", 32'(bus.hist_done), 32'd1);

    // back-to-back accepts, border hits, finish with a same-cycle sample, stalled drain
    do_reset();
    put(129, 8'hFF); step();
    put(130, 8'hFF); step();
    put(131, 8'hFF); step();
    put(0, 8'h10);   step();
    put(255, 8'h10); step();
    put(200, 8'h07);
    bus.finish = 1'b1;
    step();
    bus.lbp_valid = 1'b0;
    chk("t2_berr_early", 32'(bus.border_err), 32'd1);
    drain(1);
    chk("t2_bin255", 32'(got[255]), 32'd3);
    chk("t2_bin16", 32'(got[16]), 32'd0);
    chk("t2_bin7", 32'(got[7]), 32'd1);
    chk("t2_handshakes", 32'(hs_cnt), 32'd256);
    chk("t2_berr_late", 32'(bus.border_err), 32'd1);

    // random image, reset after 100 bins drained
    do_reset();
    random_image(150);
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b1;
    for (int k = 0; k < 3000 && hs_cnt < 100; k++) begin
      bus.hist_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("t3_partial", 32'(hs_cnt), 32'd100);
    rst_n = 1'b0;
    #1;
    chk("t3_rst_valid", 32'(bus.hist_valid), 32'd0);
    chk("t3_rst_bin", 32'(bus.hist_bin), 32'd0);
    chk("t3_rst_count", 32'(bus.hist_count), 32'd0);
    chk("t3_rst_done", 32'(bus.hist_done), 32'd0);
    chk("t3_rst_berr", 32'(bus.border_err), 32'd0);
    do_reset();

    // fresh random image after the aborted drain
    random_image(250);
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b1;
    drain(2);
    chk("t4_handshakes", 32'(hs_cnt), 32'd256);
    for (int b = 0; b < 256; b++)
      if (got[b] != m_bin[b]) chk("t4_bin", 32'(got[b]), 32'(m_bin[b]));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
